mcpu_alu_arbiter: RTL and testbench
===================================

# mcpu_alu_arbiter

Shares one MCPU ALU instance between two requesters (e.g. fetch-side address calc and execute stage) using a valid/ready handshake and round-robin arbitration. A 3-state FSM latches the granted operands, captures the ALU result, and holds it for the owning requester until accepted. The block sits between the requesters and the combinational ALU, and is the only driver of the ALU's opcode and operand inputs.

## Interface
- CMD_SIZE, 2, opcode width; encoding 00 AND, 01 OR, 10 XOR, 11 ADD
- WORD_SIZE, 2, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_opcode / req1_opcode  in  CMD_SIZE  operation
- req0_r1, req0_r2 / req1_r1, req1_r2  in  WORD_SIZE  operands
- rsp0_valid / rsp1_valid  out  1  result held for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_out  out  WORD_SIZE  result (shared, qualified by rspN_valid)
- rsp_ovf  out  1  carry-out of ADD; 0 for logical ops
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: reqN_ready = 1 only for the requester picked by round-robin (combinational on valids); others 0. On valid&ready, latch opcode/r1/r2 and grant id, then go to EXEC. No valid: stay.
- Round-robin: pointer reset to 0 (req0 preferred). With both valid, the pointer side wins. After a response completes for requester i, the pointer moves to the other side. With a single valid, that side wins regardless of pointer.
- EXEC: latched operands drive the ALU. Capture out into rsp_out. rsp_ovf = ALU OVERFLOW if opcode==11, else 0. Go to RESP.
- Arithmetic: ADD is unsigned, {rsp_ovf, rsp_out} = r1 + r2 (WORD_SIZE+1 bits). Logical ops are bitwise.
- RESP: rspG_valid = 1 for the granted id only. Result registers are stable. On rspG_ready, go to IDLE and update the pointer. No new request is accepted in RESP.
- Protocol rule: a requester holds valid and operands stable until ready. Dropping valid early is a requester error and is not checked.

## Timing
- Reset values: all reqN_ready = 0 during reset, rspN_valid = 0, rsp_out = 0, rsp_ovf = 0, busy = 0, pointer = 0, state IDLE.
- Accept at edge T. EXEC during T..T+1. rspG_valid rises after edge T+1. If rsp_ready is already high, return to IDLE at T+2.
- Minimum occupancy is 3 cycles per op; the next accept is no earlier than T+3.
- Reset asserted mid-operation: the result is discarded, no response is issued, and the pointer returns to 0.
- rsp_ready held low: stay in RESP indefinitely. Other requester waits with reqN_ready = 0.
- rspN_ready asserted for the non-granted id: ignored.

## Configuration
- MCPU_ALU_ARB_STATS_EN defined: adds outputs gnt0_cnt, gnt1_cnt, ovf_cnt (16 bits each).
  - gntN_cnt counts accepts per requester; ovf_cnt counts ADD results with carry.
  - All three saturate at 16'hFFFF and reset to 0.
- Macro undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package mcpu_pkg:
  - opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11
  - FSM state typedef (IDLE, EXEC, RESP)
- Instantiates the existing ALU unchanged, passing CMD_SIZE/WORD_SIZE.
- One new sub-module: mcpu_rr_pick (2-input round-robin pick from valids + pointer, combinational).

## Test plan
- Single ADD: req0 op=11, r1=3, r2=2 → req0_ready high on accept cycle; 2 cycles later rsp0_valid=1, rsp_out=1, rsp_ovf=1.
- Logical ops: req1 XOR 2,3 → rsp_out=1, rsp_ovf=0. AND 3,2 → 2. OR 1,2 → 3.
- Contention: both valid from reset → req0 served first, then req1. Both re-asserted → req1 first next round.
- Backpressure: rsp0_ready low for 5 cycles → rsp0_valid, rsp_out stable; req1_ready stays 0; the 3-cycle path resumes after release.
- Reset during EXEC: rst_n low 1 cycle → no rspN_valid, busy=0; the next both-valid pair grants req0.
- STATS_EN: 4 ADDs of 3+3 via req1 → gnt1_cnt=4, ovf_cnt=4, gnt0_cnt=0.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared opcode encodings and arbiter FSM states for the MCPU ALU block.
package mcpu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/mcpu_alu.sv
// Combinational MCPU ALU: AND/OR/XOR/unsigned ADD with carry-out.
// Zero latency; no handshake.
module mcpu_alu
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 2
) (
  input  logic [CMD_SIZE-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 overflow
);

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (opcode)
      OP_AND: out = r1 & r2;
      OP_OR:  out = r1 | r2;
      OP_XOR: out = r1 ^ r2;
      OP_ADD: {overflow, out} = {1'b0, r1} + {1'b0, r2};
    endcase
  end

endmodule

// File: rtl/mcpu_rr_pick.sv
// Two-way round-robin pick: a lone valid always wins, a tie goes to the pointer side.
// Combinational, one-hot (or zero) result.
module mcpu_rr_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = valid;
    if (valid == 2'b11) pick = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mcpu_alu_arbiter.sv
// Arbitrates two valid/ready requesters onto one ALU; 3 cycles min per op, result held until taken.
// Optional saturating grant/overflow counters when MCPU_ALU_ARB_STATS_EN is defined.
module mcpu_alu_arbiter
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [CMD_SIZE-1:0]  req0_opcode,
  input  logic [WORD_SIZE-1:0] req0_r1,
  input  logic [WORD_SIZE-1:0] req0_r2,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [CMD_SIZE-1:0]  req1_opcode,
  input  logic [WORD_SIZE-1:0] req1_r1,
  input  logic [WORD_SIZE-1:0] req1_r2,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [WORD_SIZE-1:0] rsp_out,
  output logic                 rsp_ovf,
  output logic                 busy
`ifdef MCPU_ALU_ARB_STATS_EN
  ,
  output logic [15:0]          gnt0_cnt,
  output logic [15:0]          gnt1_cnt,
  output logic [15:0]          ovf_cnt
`endif
);

  state_t               state, state_nxt;
  logic                 ptr;
  logic                 gnt_id;
  logic [CMD_SIZE-1:0]  op_q;
  logic [WORD_SIZE-1:0] r1_q, r2_q;
  logic [1:0]           pick, req_ready;
  logic                 accept, rsp_take;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 alu_ovf;

  mcpu_rr_pick u_pick (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr),
    .pick  (pick)
  );

  mcpu_alu #(.CMD_SIZE(CMD_SIZE), .WORD_SIZE(WORD_SIZE)) u_alu (
    .opcode   (op_q),
    .r1       (r1_q),
    .r2       (r2_q),
    .out      (alu_out),
    .overflow (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    rsp_take  = 1'b0;
    case (state)
      IDLE: begin
        // Ready is masked while reset is held so nothing looks accepted.
        req_ready = pick & {2{rst_n}};
        if (|pick) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (gnt_id ? rsp1_ready : rsp0_ready) begin
          rsp_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = (state == RESP) && !gnt_id;
  assign rsp1_valid = (state == RESP) &&  gnt_id;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      gnt_id  <= 1'b0;
      op_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      rsp_out <= '0;
      rsp_ovf <= 1'b0;
    end else begin
      if (accept) begin
        gnt_id <= pick[1];
        op_q   <= pick[1] ? req1_opcode : req0_opcode;
        r1_q   <= pick[1] ? req1_r1     : req0_r1;
        r2_q   <= pick[1] ? req1_r2     : req0_r2;
      end
      if (state == EXEC) begin
        rsp_out <= alu_out;
        rsp_ovf <= (op_q == OP_ADD) && alu_ovf;
      end
      if (rsp_take) ptr <= ~gnt_id;
    end
  end

`ifdef MCPU_ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (accept && !pick[1] && gnt0_cnt != 16'hFFFF) gnt0_cnt <= gnt0_cnt + 16'd1;
      if (accept &&  pick[1] && gnt1_cnt != 16'hFFFF) gnt1_cnt <= gnt1_cnt + 16'd1;
      if (state == EXEC && op_q == OP_ADD && alu_ovf && ovf_cnt != 16'hFFFF)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// Self-checking bench for mcpu_alu_arbiter: directed cases then randomized traffic vs a reference model.
module tb_mcpu_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_opcode = '0, req1_opcode = '0;
  logic [1:0] req0_r1 = '0, req0_r2 = '0, req1_r1 = '0, req1_r2 = '0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [1:0] rsp_out;
  logic       rsp_ovf;
  logic       busy;
`ifdef MCPU_ALU_ARB_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt, ovf_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  mcpu_alu_arbiter #(.CMD_SIZE(2), .WORD_SIZE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_r1     (req0_r1),
    .req0_r2     (req0_r2),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_r1     (req1_r1),
    .req1_r2     (req1_r2),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp_out     (rsp_out),
    .rsp_ovf     (rsp_ovf),
    .busy        (busy)
`ifdef MCPU_ALU_ARB_STATS_EN
    ,
    .gnt0_cnt    (gnt0_cnt),
    .gnt1_cnt    (gnt1_cnt),
    .ovf_cnt     (ovf_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, result} from the opcode table using plain integer arithmetic.
  function automatic logic [2:0] model(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    int s;
    case (op)
      2'b00:   s = int'(a & b);
      2'b01:   s = int'(a | b);
      2'b10:   s = int'(a ^ b);
      default: s = int'(a) + int'(b);
    endcase
    return 3'(s);
  endfunction

  task automatic set_req(input int id, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    if (id == 0) begin
      req0_valid = 1'b1; req0_opcode = op; req0_r1 = a; req0_r2 = b;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_r1 = a; req1_r2 = b;
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  // Called just after a negedge with the current request pattern driven.
  task automatic serve(input int hold);
    int         w;
    logic [2:0] er;
    logic [1:0] held;
    if (req0_valid && req1_valid) w = exp_ptr;
    else                          w = req1_valid ? 1 : 0;
    er = (w == 1) ? model(req1_opcode, req1_r1, req1_r2)
                  : model(req0_opcode, req0_r1, req0_r2);
    #1;
    check("accept_req0_ready", req0_ready, w == 0);
    check("accept_req1_ready", req1_ready, w == 1);
    @(negedge clk);
    check("exec_busy", busy, 1);
    check("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("exec_req_ready", {req1_ready, req0_ready}, 0);
    if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    @(negedge clk);
    check("resp_valid", {rsp1_valid, rsp0_valid}, (w == 1) ? 2'b10 : 2'b01);
    check("resp_out", rsp_out, er[1:0]);
    check("resp_ovf", rsp_ovf, er[2]);
    held = rsp_out;
    for (int i = 0; i < hold; i++) begin
      if (w == 0) rsp1_ready = 1'($urandom_range(1)); else rsp0_ready = 1'($urandom_range(1));
      @(negedge clk);
      check("hold_valid", {rsp1_valid, rsp0_valid}, (w == 1) ? 2'b10 : 2'b01);
      check("hold_out", rsp_out, held);
      check("hold_req_ready", {req1_ready, req0_ready}, 0);
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    if (w == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    check("done_busy", busy, 0);
    check("done_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    exp_ptr = 1 - w;
  endtask

  initial begin
    // Reset state with both requesters already asserting valid.
    set_req(0, 2'b11, 2'd1, 2'd1);
    set_req(1, 2'b11, 2'd1, 2'd1);
    #2;
    check("rst_req_ready", {req1_ready, req0_ready}, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_out", rsp_out, 0);
    check("rst_ovf", rsp_ovf, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // Single ADD and the logical ops.
    set_req(0, 2'b11, 2'd3, 2'd2); serve(0);
    set_req(1, 2'b10, 2'd2, 2'd3); serve(0);
    set_req(1, 2'b00, 2'd3, 2'd2); serve(0);
    set_req(0, 2'b01, 2'd1, 2'd2); serve(0);

    // Contention from reset, then re-assertion flips the winner.
    do_reset();
    set_req(0, 2'b11, 2'd2, 2'd2);
    set_req(1, 2'b01, 2'd2, 2'd1);
    serve(0);
    set_req(0, 2'b10, 2'd3, 2'd1);
    serve(0);
    serve(0);

    // Backpressure on req0 with req1 waiting.
    set_req(0, 2'b11, 2'd3, 2'd3);
    set_req(1, 2'b00, 2'd1, 2'd3);
    serve(5);
    serve(0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      if (!req0_valid && $urandom_range(1) == 1)
        set_req(0, 2'($urandom), 2'($urandom), 2'($urandom));
      if (!req1_valid && $urandom_range(1) == 1)
        set_req(1, 2'($urandom), 2'($urandom), 2'($urandom));
      if (!req0_valid && !req1_valid)
        set_req(int'($urandom_range(1)), 2'($urandom), 2'($urandom), 2'($urandom));
      serve(int'($urandom_range(3)));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset during EXEC after the pointer has moved to req1.
    do_reset();
    set_req(0, 2'b00, 2'd3, 2'd3); serve(0);
    set_req(0, 2'b11, 2'd1, 2'd1);
    @(negedge clk);
    check("mid_exec_busy", busy, 1);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    set_req(0, 2'b01, 2'd1, 2'd0);
    set_req(1, 2'b01, 2'd2, 2'd0);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("mid_rst_req_ready", {req1_ready, req0_ready}, 0);
    check("mid_rst_out", rsp_out, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      check("post_rst_busy", busy, 0);
    end
    set_req(0, 2'b01, 2'd1, 2'd0);
    set_req(1, 2'b01, 2'd2, 2'd0);
    serve(0);
    serve(0);

`ifdef MCPU_ALU_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1, 2'b11, 2'd3, 2'd3);
      serve(0);
    end
    check("gnt0_cnt", gnt0_cnt, 0);
    check("gnt1_cnt", gnt1_cnt, 4);
    check("ovf_cnt", ovf_cnt, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
